// File: rtl/dmem_ctrl.sv
// Data-memory sequencer: serialises CPU MEM-stage and debug-port accesses onto one
// single-port synchronous RAM, stalling the pipeline until each CPU access completes.

package dmem_pkg;
  // MEM-stage opcodes that access data memory; every other opcode is a non-request.
  localparam logic [5:0] ILW = 6'h23;
  localparam logic [5:0] ISW = 6'h2b;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {OWN_CPU, OWN_DBG} owner_t;
endpackage

module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        M_op,
  input  logic [31:0]       M_valE,
  input  logic [31:0]       M_valA,
  output logic [31:0]       m_valM,
  output logic              m_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int SC_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);
  localparam logic [SC_W-1:0]  SC_LIMIT = SC_W'(STARVE_MAX);

  state_t           state_q, state_d;
  owner_t           owner_q;
  logic             we_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SC_W-1:0]  starve_q;

  logic              cpu_req;
  logic              grant_cpu;
  logic              grant_dbg;
  logic              grant;
  owner_t            grant_owner;
  logic              grant_we;
  logic [ADDR_W-1:0] grant_addr;
  logic [31:0]       grant_wdata;

  // Only the word-address bits of the CPU address reach the RAM.
  logic unused_valE_hi;
  assign unused_valE_hi = ^M_valE[31:ADDR_W];

  // Arbitration: debug wins when the CPU is quiet or has been favoured long enough.
  always_comb begin
    cpu_req     = (M_op == ILW) || (M_op == ISW);
    grant_dbg   = (state_q == IDLE) && d_req && (!cpu_req || (starve_q >= SC_LIMIT));
    grant_cpu   = (state_q == IDLE) && cpu_req && !grant_dbg;
    grant       = grant_dbg || grant_cpu;
    grant_owner = grant_dbg ? OWN_DBG : OWN_CPU;
    grant_we    = grant_dbg ? d_we : (M_op == ISW);
    grant_addr  = grant_dbg ? d_addr : M_valE[ADDR_W-1:0];
    grant_wdata = grant_dbg ? d_wdata : M_valA;
  end

  // NOTE: every output of this block is assigned before the case, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    m_stall = cpu_req && !((state_q == DONE) && (owner_q == OWN_CPU));
    d_ack   = (state_q == DONE) && (owner_q == OWN_DBG);
    case (state_q)
      IDLE:    if (grant) state_d = ISSUE;
      ISSUE:   state_d = we_q ? DONE : WAIT;
      WAIT:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_CPU;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= grant_owner;
        we_q    <= grant_we;
      end
      if (state_q == ISSUE) begin
        cnt_q <= CNT_INIT;
      end else if ((state_q == WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // RAM command registers: enable pulses in ISSUE; address/data hold the latched request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= grant;
      mem_we <= grant && grant_we;
      if (grant) begin
        mem_addr  <= grant_addr;
        mem_wdata <= grant_wdata;
      end
    end
  end

  // Read data lands on the last WAIT cycle; only the owner's result register moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valM  <= '0;
      d_rdata <= '0;
    end else if ((state_q == WAIT) && (cnt_q == '0)) begin
      if (owner_q == OWN_CPU) begin
        m_valM <= mem_rdata;
      end else begin
        d_rdata <= mem_rdata;
      end
    end
  end

  // Counts CPU grants that overtook a waiting debug request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (state_q == IDLE) begin
      if (grant_dbg || !d_req) begin
        starve_q <= '0;
      end else if (grant_cpu && (starve_q != SC_LIMIT)) begin
        starve_q <= starve_q + SC_W'(1);
      end
    end
  end

  a_single_issue : assert property (@(posedge clk) disable iff (!rst_n) mem_en |=> !mem_en);
  a_en_in_issue  : assert property (@(posedge clk) disable iff (!rst_n) mem_en == (state_q == ISSUE));
  a_ack_pulse    : assert property (@(posedge clk) disable iff (!rst_n) d_ack |=> !d_ack);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: transaction-level scoreboard checked every cycle,
// directed scenarios with literal expectations, then constrained-random traffic.

module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int ADDR_W     = 6;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 2;
  localparam int DEPTH      = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic [5:0]        M_op;
  logic [31:0]       M_valE;
  logic [31:0]       M_valA;
  logic [31:0]       m_valM;
  logic              m_stall;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int checks = 0;
  int errors = 0;

  dmem_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .M_op(M_op), .M_valE(M_valE), .M_valA(M_valA), .m_valM(m_valM), .m_stall(m_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] init_word(input int i);
    return (32'h9e37_79b9 * 32'(i + 1)) ^ 32'h5a5a_0f0f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Synchronous RAM with RD_LAT-cycle read pipeline; idle slots carry junk.
  logic [31:0] ram [DEPTH];
  logic [31:0] rd_pipe [RD_LAT];
  bit ram_loaded = 1'b0;
  assign mem_rdata = rd_pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : $urandom;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Scoreboard: each granted access occupies a fixed number of cycles
  // (3 for a write, 3+RD_LAT for a read); expectations follow the cycle index.
  logic [31:0]       mdl_mem [DEPTH];
  bit                mdl_loaded = 1'b0;
  bit                busy = 1'b0;
  int                phase, len;
  int                starve = 0;
  bit                t_dbg, t_we;
  logic [ADDR_W-1:0] t_addr;
  logic [31:0]       t_wdata, t_rdval;
  logic [31:0]       exp_valM = '0;
  logic [31:0]       exp_drd = '0;

  always @(negedge clk) begin : scoreboard
    logic cpu_req, g_dbg, g_cpu, done;
    if (!mdl_loaded) begin
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = init_word(i);
      mdl_loaded = 1'b1;
    end
    cpu_req = (M_op == ILW) || (M_op == ISW);
    if (!rst_n) begin
      busy = 1'b0; starve = 0; exp_valM = '0; exp_drd = '0;
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_d_ack", d_ack, 0);
      check("rst_m_valM", m_valM, 0);
      check("rst_d_rdata", d_rdata, 0);
      check("rst_m_stall", m_stall, cpu_req);
    end else if (!busy) begin
      check("idle_mem_en", mem_en, 0);
      check("idle_d_ack", d_ack, 0);
      check("idle_m_stall", m_stall, cpu_req);
      check("idle_m_valM", m_valM, exp_valM);
      check("idle_d_rdata", d_rdata, exp_drd);
      g_dbg = d_req && (!cpu_req || (starve >= STARVE_MAX));
      g_cpu = cpu_req && !g_dbg;
      if (g_dbg || !d_req) starve = 0;
      else if (g_cpu) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
      if (g_dbg || g_cpu) begin
        busy    = 1'b1;
        phase   = 1;
        t_dbg   = g_dbg;
        t_we    = g_dbg ? d_we : (M_op == ISW);
        t_addr  = g_dbg ? d_addr : M_valE[ADDR_W-1:0];
        t_wdata = g_dbg ? d_wdata : M_valA;
        len     = t_we ? 3 : 3 + RD_LAT;
        if (t_we) mdl_mem[t_addr] = t_wdata;
        else t_rdval = mdl_mem[t_addr];
      end
    end else begin
      done = (phase == len - 1);
      if (done && !t_we) begin
        if (t_dbg) exp_drd = t_rdval;
        else exp_valM = t_rdval;
      end
      check("acc_mem_en", mem_en, (phase == 1));
      check("acc_mem_we", mem_we, (phase == 1) && t_we);
      if (phase == 1) begin
        check("acc_mem_addr", mem_addr, t_addr);
        if (t_we) check("acc_mem_wdata", mem_wdata, t_wdata);
      end
      check("acc_m_stall", m_stall, cpu_req && !(done && !t_dbg));
      check("acc_d_ack", d_ack, done && t_dbg);
      check("acc_m_valM", m_valM, exp_valM);
      check("acc_d_rdata", d_rdata, exp_drd);
      phase++;
      if (done) busy = 1'b0;
    end
  end

  // Drives a CPU access and holds it until the stall drops; returns stall count.
  task automatic cpu_access(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input string tag, output int stalls, output logic [31:0] valm);
    bit ok = 1'b0;
    M_op = op; M_valE = addr; M_valA = data;
    stalls = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_stall) stalls++;
      else begin ok = 1'b1; break; end
    end
    check({tag, "_completes"}, ok, 1);
    valm = m_valM;
    tick();
    M_op = 6'h00;
  endtask

  task automatic dbg_access(input logic we, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                            input string tag, output int cycles, output int en_cnt,
                            output logic [31:0] rdata, output logic [ADDR_W-1:0] seen_addr,
                            output logic seen_we);
    bit ok = 1'b0;
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    cycles = 0; en_cnt = 0; seen_addr = '0; seen_we = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cycles++;
      if (mem_en) begin en_cnt++; seen_addr = mem_addr; seen_we = mem_we; end
      if (d_ack) begin ok = 1'b1; break; end
    end
    check({tag, "_acked"}, ok, 1);
    rdata = d_rdata;
    tick();
    d_req = 1'b0;
  endtask

  initial begin
    int st, cyc, en_cnt, nd;
    logic [31:0] v, rd;
    logic [ADDR_W-1:0] sa;
    logic sw, stall_seen;
    bit ok;
    logic [5:0] pattern, op;

    rst_n = 1'b1; M_op = ISW; M_valE = 32'd5; M_valA = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_stall_held_isw", m_stall, 1);
    check("reset_mem_en", mem_en, 0);
    check("reset_m_valM", m_valM, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; M_op = 6'h00;
    tick();

    // CPU store then load of the same word
    cpu_access(ISW, 32'd5, 32'hdead_beef, "st5", st, v);
    check("store_stall_cycles", st, 2);
    cpu_access(ILW, 32'hffff_ffc5, 32'h0, "ld5", st, v);
    check("load_stall_cycles", st, 3 + RD_LAT - 1);
    check("load_value", v, 32'hdead_beef);
    cpu_access(ISW, 32'd6, 32'h0000_0001, "st6", st, v);
    check("store_keeps_valM", v, 32'hdead_beef);

    // Debug write and read-back with the CPU idle
    dbg_access(1'b1, ADDR_W'(3), 32'h1234_5678, "dwr3", cyc, en_cnt, rd, sa, sw);
    check("dbg_write_cycles", cyc, 3);
    check("dbg_write_en_cnt", en_cnt, 1);
    check("dbg_write_we", sw, 1);
    check("dbg_write_addr", sa, 3);
    dbg_access(1'b0, ADDR_W'(3), 32'h0, "drd3", cyc, en_cnt, rd, sa, sw);
    check("dbg_read_cycles", cyc, 3 + RD_LAT);
    check("dbg_read_value", rd, 32'h1234_5678);

    // Continuous CPU loads against a held debug request: C C D C C D
    M_op = ILW; M_valE = 32'd3; d_req = 1'b1; d_we = 1'b0; d_addr = ADDR_W'(5);
    nd = 0; pattern = '0;
    for (int i = 0; i < 100 && nd < 6; i++) begin
      @(negedge clk);
      if (d_ack) begin
        pattern[nd] = 1'b1;
        check("starve_d_rdata", d_rdata, 32'hdead_beef);
        nd++;
      end else if (!m_stall) begin
        check("starve_m_valM", m_valM, 32'h1234_5678);
        nd++;
      end
    end
    check("starve_done_count", nd, 6);
    check("starve_grant_order", pattern, 6'b100100);
    tick();
    M_op = 6'h00; d_req = 1'b0;
    tick();

    // Simultaneous CPU and debug reads: CPU first, debug in the following IDLE
    dbg_access(1'b1, ADDR_W'(9), 32'hcafe_f00d, "dwr9", cyc, en_cnt, rd, sa, sw);
    M_op = ILW; M_valE = 32'd5; d_req = 1'b1; d_we = 1'b0; d_addr = ADDR_W'(9);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!m_stall) begin ok = 1'b1; break; end
    end
    check("both_cpu_done", ok, 1);
    check("both_cpu_first", d_ack, 0);
    check("both_cpu_value", m_valM, 32'hdead_beef);
    tick();
    M_op = 6'h00;
    ok = 1'b0; cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (d_ack) begin ok = 1'b1; break; end
    end
    check("both_dbg_acked", ok, 1);
    check("both_dbg_cycles", cyc, 3 + RD_LAT);
    check("both_dbg_value", d_rdata, 32'hcafe_f00d);
    tick();
    d_req = 1'b0;
    tick();

    // Reset in the WAIT phase of a CPU load, then the held load restarts
    M_op = ILW; M_valE = 32'd3;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midreset_mem_en", mem_en, 0);
    check("midreset_m_valM", m_valM, 0);
    check("midreset_d_rdata", d_rdata, 0);
    tick();
    tick();
    rst_n = 1'b1;
    cpu_access(ILW, 32'd3, 32'h0, "ld3_restart", st, v);
    check("restart_stall_cycles", st, 3 + RD_LAT - 1);
    check("restart_value", v, 32'h1234_5678);

    // Random traffic; pipeline inputs only move when the previous cycle did not stall
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      stall_seen = m_stall;
      @(posedge clk); #1;
      if (!stall_seen) begin
        case ($urandom_range(0, 4))
          0, 1:    op = ILW;
          2:       op = ISW;
          default: begin
            op = 6'($urandom);
            if (op == ILW || op == ISW) op = 6'h00;
          end
        endcase
        M_op = op; M_valE = $urandom; M_valA = $urandom;
      end
      if ($urandom_range(0, 4) == 0) d_req = ~d_req;
      if ($urandom_range(0, 2) == 0) begin
        d_we = 1'($urandom); d_addr = ADDR_W'($urandom); d_wdata = $urandom;
      end
    end
    @(negedge clk);
    stall_seen = m_stall;
    while (stall_seen) begin
      @(negedge clk);
      stall_seen = m_stall;
    end
    @(posedge clk); #1;
    M_op = 6'h00; d_req = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Sequencing controller and two-port arbiter for the data memory. Sits between the pipeline MEM stage (M_op/M_valE/M_valA in, m_valM out) and a synchronous, fixed-read-latency single-port data RAM. It shares that RAM with a debug/loader port and stalls the pipeline until each CPU access completes. Bounded-priority arbitration keeps the CPU favoured while guaranteeing debug progress.

## Interface
Parameters:
- ADDR_W, 6, word-address width; RAM depth 2^ADDR_W words
- RD_LAT, 1, RAM read latency in cycles (>=1)
- STARVE_MAX, 4, max consecutive CPU grants while d_req waits; 0 = debug strict priority

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- M_op  in  6  MEM-stage opcode; `ILW`/`ISW` from def.v are requests, all other values none
- M_valE  in  32  CPU word address; bits [ADDR_W-1:0] used
- M_valA  in  32  CPU store data
- m_valM  out  32  CPU load result, registered
- m_stall  out  1  pipeline stall request
- d_req  in  1  debug request, level
- d_we  in  1  debug write (1) / read (0)
- d_addr  in  ADDR_W  debug word address
- d_wdata  in  32  debug write data
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  32  debug read result, registered
- mem_en, mem_we  out  1 each  RAM enable / write enable, registered
- mem_addr  out  ADDR_W  RAM address, registered
- mem_wdata  out  32  RAM write data, registered
- mem_rdata  in  32  RAM read data, valid RD_LAT cycles after the enable cycle

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Latched: owner (CPU/DBG), we, addr, wdata.
- IDLE: cpu_req = M_op∈{ILW,ISW}. Grant DBG if d_req and (!cpu_req or starve_cnt>=STARVE_MAX); else grant CPU if cpu_req. On grant latch request, load mem_* for next cycle, go ISSUE. No request: stay IDLE.
- starve_cnt: +1 (saturating) on a CPU grant with d_req high; cleared on a DBG grant or in IDLE with d_req low.
- ISSUE: mem_en=1 for exactly one cycle. Write -> DONE. Read -> WAIT with cnt=RD_LAT-1.
- WAIT: cnt==0 -> capture mem_rdata into m_valM (CPU) or d_rdata (DBG), go DONE; else cnt-1.
- DONE: owner CPU: m_stall low this cycle. Owner DBG: d_ack=1. Then IDLE.
- m_stall = cpu_req && !(state==DONE && owner==CPU). Decoded from registered state plus M_op; asserts in the same cycle as the request.
- Pipeline holds M_* stable while m_stall=1. Changes after grant are ignored.
- d_req may drop before grant (withdrawn, no access). Once latched, a DBG transaction always completes.
- m_valM/d_rdata update only on own-owner reads and hold otherwise. Writes never change them.
- Reset (any state, mid-access included): state IDLE, starve_cnt 0, m_valM 0, d_rdata 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, d_ack 0. The in-flight access is abandoned.

## Timing
- CPU store: request cycle c0 (IDLE) -> ISSUE c1 -> DONE c2. m_stall high c0-c1, low c2.
- CPU load: 3+RD_LAT cycles total. m_valM valid in the DONE cycle and held after.
- DBG: d_ack in the DONE cycle, with the same cycle counts. d_rdata valid with d_ack.
- Back-to-back: the next grant is evaluated in the IDLE cycle following DONE. At most one access is outstanding.
- If a CPU request is pending while DBG is serviced, m_stall stays high throughout.

## Test plan
- Reset -> all outputs 0. With M_op=`ISW` held during reset, m_stall=1 and mem_en=0.
- CPU `ISW` addr 5 data 0xDEADBEEF, then `ILW` addr 5, RD_LAT=2 -> store stalls 2 cycles. Load stalls 4 cycles. m_valM=0xDEADBEEF in its DONE cycle.
- d_req write addr 3 = 0x12345678 with CPU idle -> mem_en one cycle with mem_we=1, addr 3. d_ack 3 cycles after d_req rises.
- STARVE_MAX=2, CPU issues continuous `ILW`, d_req held high -> grants CPU, CPU, DBG, CPU, CPU, DBG. d_ack after each DBG slot.
- Simultaneous CPU and DBG read with starve_cnt=0 -> CPU first. DBG granted in the IDLE after the CPU DONE. d_rdata correct.
- rst_n low during WAIT of a CPU load -> mem_en=0 and m_valM=0 immediately. After release, the held `ILW` restarts from IDLE and completes normally.
